// File: rtl/fea_node_seq.sv
// fea_node_seq: time-multiplexed explicit-Euler (Jacobi) update engine for a 1-D rod of DEPTH nodes.
// Build option FEA_NODE_SAT_EN: saturate node write-back instead of two's-complement wrap.
module fea_node_seq #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned FRAC  = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [15:0]      steps,
  input  logic [WIDTH-1:0] bc_left,
  input  logic [WIDTH-1:0] bc_right,
  input  logic             abort,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [15:0]      step_cnt
);

  localparam int unsigned LW = WIDTH + 2;      // Laplacian, cannot overflow
  localparam int unsigned PW = 2 * WIDTH + 2;  // full coefficient product
  localparam int unsigned SW = PW + 1;         // value + delta before fit
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  localparam logic [2:0] CMD_PROT = 3'd0;
  localparam logic [2:0] CMD_NODE = 3'd1;
  localparam logic [2:0] CMD_COEF = 3'd2;
  localparam logic [2:0] CMD_RUN  = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAP,
    S_MUL,
    S_WB,
    S_STEP_END,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] val  [DEPTH];
  logic signed [WIDTH-1:0] coef [DEPTH];
  logic                    prot;
  logic [AW-1:0]           idx;
  logic signed [WIDTH-1:0] lold;
  logic signed [WIDTH-1:0] bcl;
  logic signed [WIDTH-1:0] bcr;
  logic signed [LW-1:0]    lap;
  logic signed [PW-1:0]    dlt;
  logic [15:0]             steps_q;
  logic                    abort_seen;

  logic                    accept_c;
  logic                    wr_ok_c;
  logic                    last_step_c;
  logic signed [WIDTH-1:0] right_c;
  logic signed [LW-1:0]    lap_c;
  logic signed [PW-1:0]    prod_c;
  logic signed [SW-1:0]    sum_c;
  logic signed [WIDTH-1:0] fit_c;

  assign accept_c    = cmd_valid && cmd_ready;
  assign wr_ok_c     = !prot && (32'(addr) < DEPTH);
  assign last_step_c = (16'(step_cnt + 16'd1) == steps_q) || abort_seen || abort;
  assign rd_data     = (32'(rd_addr) < DEPTH) ? val[rd_addr] : '0;

  // Shared datapath; lold carries the pre-update left neighbour so in-place writes stay Jacobi.
  always_comb begin
    right_c = (idx == LAST) ? bcr : val[idx + AW'(1)];
    lap_c   = LW'(lold) + LW'(right_c) - (LW'(val[idx]) <<< 1);
    prod_c  = PW'(coef[idx]) * PW'(lap);
    sum_c   = SW'(val[idx]) + SW'(dlt);
  end

`ifdef FEA_NODE_SAT_EN
  always_comb begin
    if (sum_c[SW-1:WIDTH-1] == {(SW-WIDTH+1){sum_c[SW-1]}}) begin
      fit_c = sum_c[WIDTH-1:0];
    end else if (sum_c[SW-1]) begin
      fit_c = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      fit_c = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  logic unused_hi;
  assign fit_c     = sum_c[WIDTH-1:0];
  assign unused_hi = ^sum_c[SW-1:WIDTH];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept_c && (cmd == CMD_RUN)) begin
          state_nxt = (steps == 16'd0) ? S_DONE : S_LAP;
        end
      end
      S_LAP:      state_nxt = S_MUL;
      S_MUL:      state_nxt = S_WB;
      S_WB:       state_nxt = (idx == LAST) ? S_STEP_END : S_LAP;
      S_STEP_END: state_nxt = last_step_c ? S_DONE : S_LAP;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Storage, host writes and per-phase datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < int'(DEPTH); n++) begin
        val[n]  <= '0;
        coef[n] <= '0;
      end
      prot       <= 1'b0;
      idx        <= '0;
      lold       <= '0;
      bcl        <= '0;
      bcr        <= '0;
      lap        <= '0;
      dlt        <= '0;
      steps_q    <= '0;
      step_cnt   <= '0;
      abort_seen <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept_c) begin
            unique case (cmd)
              CMD_PROT: prot <= wdata[0];
              CMD_NODE: if (wr_ok_c) val[addr] <= wdata;
              CMD_COEF: if (wr_ok_c) coef[addr] <= wdata;
              CMD_RUN: begin
                steps_q    <= steps;
                bcl        <= bc_left;
                bcr        <= bc_right;
                lold       <= bc_left;
                step_cnt   <= '0;
                idx        <= '0;
                abort_seen <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        S_LAP: begin
          lap <= lap_c;
          if (abort) abort_seen <= 1'b1;
        end
        S_MUL: begin
          dlt <= prod_c >>> FRAC;
          if (abort) abort_seen <= 1'b1;
        end
        S_WB: begin
          lold     <= val[idx];
          val[idx] <= fit_c;
          if (idx != LAST) idx <= idx + AW'(1);
          if (abort) abort_seen <= 1'b1;
        end
        S_STEP_END: begin
          step_cnt   <= step_cnt + 16'd1;
          abort_seen <= 1'b0;
          lold       <= bcl;
          idx        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fea_node_seq.sv
// Directed, table-driven bench for fea_node_seq (DEPTH=4 main instance, DEPTH=6 for out-of-range addressing).
module tb_fea_node_seq;

  localparam logic [2:0] C_PROT = 3'd0;
  localparam logic [2:0] C_NODE = 3'd1;
  localparam logic [2:0] C_COEF = 3'd2;
  localparam logic [2:0] C_RUN  = 3'd3;

`ifdef FEA_NODE_SAT_EN
  localparam logic [31:0] EXP_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_NEG = 32'h8000_0000;
`else
  localparam logic [31:0] EXP_POS = 32'h8FFF_FFFE;
  localparam logic [31:0] EXP_NEG = 32'h7000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  cmd = 3'd4;
  logic        cmd_valid = 1'b0;
  logic [1:0]  addr = '0;
  logic [2:0]  addr2 = '0;
  logic [31:0] wdata = '0;
  logic [15:0] steps = '0;
  logic [31:0] bc_left = '0;
  logic [31:0] bc_right = '0;
  logic        abort = 1'b0;
  logic [1:0]  rd_addr = '0;
  logic [2:0]  rd_addr2 = '0;

  logic        cmd_ready, busy, done;
  logic [31:0] rd_data;
  logic [15:0] step_cnt;
  logic        unused_rdy2, unused_busy2, unused_done2;
  logic [15:0] unused_cnt2;
  logic [31:0] rd_data2;

  int total = 0;
  int bad   = 0;
  int dat;
  int seen;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [12];

  fea_node_seq #(.WIDTH(32), .FRAC(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .addr(addr), .wdata(wdata), .steps(steps), .bc_left(bc_left), .bc_right(bc_right),
    .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .step_cnt(step_cnt)
  );

  fea_node_seq #(.WIDTH(32), .FRAC(16), .DEPTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(unused_rdy2),
    .addr(addr2), .wdata(wdata), .steps(steps), .bc_left(bc_left), .bc_right(bc_right),
    .abort(abort), .rd_addr(rd_addr2), .rd_data(rd_data2), .busy(unused_busy2),
    .done(unused_done2), .step_cnt(unused_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    check(name, rd_data, exp);
  endtask

  // Called at/after a negedge while idle; returns at the following negedge.
  task automatic do_cmd(input logic [2:0] op, input logic [1:0] a, input logic [31:0] wd);
    cmd = op; addr = a; addr2 = {1'b0, a}; wdata = wd; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_cmd6(input logic [2:0] op, input logic [2:0] a, input logic [31:0] wd);
    cmd = op; addr2 = a; addr = a[1:0]; wdata = wd; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Issues RUN at edge 0 and reports the cycle in which done is high (-1 on timeout).
  task automatic run(input logic [15:0] s, input logic [31:0] bl, input logic [31:0] br,
                     input int abort_at, output int done_at);
    cmd = C_RUN; steps = s; bc_left = bl; bc_right = br; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    done_at = -1;
    for (int c = 1; c <= 2000; c++) begin
      abort = (c == abort_at);
      #1;
      if (c == 1 && s != 16'd0) check("busy_cycle1", 32'({busy, cmd_ready}), 32'd2);
      if (done) begin
        done_at = c;
        break;
      end
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  task automatic post_done(input string name);
    @(negedge clk);
    #1;
    check(name, 32'({done, cmd_ready, busy}), 32'b010);
  endtask

  initial begin
    vt[0]  = '{C_NODE, 2'd0, 32'h1111_1111, 2'd0, 32'h1111_1111};
    vt[1]  = '{C_NODE, 2'd3, 32'hDEAD_BEEF, 2'd3, 32'hDEAD_BEEF};
    vt[2]  = '{C_NODE, 2'd1, 32'h8000_0000, 2'd1, 32'h8000_0000};
    vt[3]  = '{3'd5,   2'd1, 32'h0000_0055, 2'd1, 32'h8000_0000};
    vt[4]  = '{C_PROT, 2'd0, 32'h0000_0001, 2'd3, 32'hDEAD_BEEF};
    vt[5]  = '{C_NODE, 2'd2, 32'h0000_1234, 2'd2, 32'h0000_0000};
    vt[6]  = '{C_NODE, 2'd0, 32'h0000_0000, 2'd0, 32'h1111_1111};
    vt[7]  = '{C_PROT, 2'd0, 32'hFFFF_FFFE, 2'd0, 32'h1111_1111};
    vt[8]  = '{C_NODE, 2'd2, 32'h0000_1234, 2'd2, 32'h0000_1234};
    vt[9]  = '{C_NODE, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};
    vt[10] = '{3'd7,   2'd2, 32'h0000_0000, 2'd2, 32'h0000_1234};
    vt[11] = '{C_NODE, 2'd3, 32'h7FFF_FFFF, 2'd3, 32'h7FFF_FFFF};

    // Reset values
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ctrl", 32'({cmd_ready, busy, done}), 32'b100);
    check("rst_step_cnt", 32'(step_cnt), 32'd0);
    for (int n = 0; n < 4; n++) rd_check($sformatf("rst_val%0d", n), 2'(n), 32'd0);

    // Out-of-range addressing on the DEPTH=6 instance
    @(negedge clk);
    do_cmd6(C_NODE, 3'd5, 32'h0000_CAFE);
    rd_addr2 = 3'd5; #1; check("d6_wr5", rd_data2, 32'h0000_CAFE);
    do_cmd6(C_NODE, 3'd6, 32'h0000_0BAD);
    rd_addr2 = 3'd6; #1; check("d6_rd6", rd_data2, 32'd0);
    rd_addr2 = 3'd7; #1; check("d6_rd7", rd_data2, 32'd0);
    rd_addr2 = 3'd5; #1; check("d6_keep5", rd_data2, 32'h0000_CAFE);
    rd_addr2 = 3'd0; #1; check("d6_keep0", rd_data2, 32'd0);
    do_cmd(C_NODE, 2'd1, 32'd0);
    do_cmd(C_NODE, 2'd2, 32'd0);

    // Command table: writes, NOPs and write protect
    for (int k = 0; k < 12; k++) begin
      do_cmd(vt[k].op, vt[k].a, vt[k].wd);
      rd_check($sformatf("vec%0d", k), vt[k].ra, vt[k].exp);
    end

    // Jacobi check
    for (int n = 0; n < 4; n++) begin
      do_cmd(C_NODE, 2'(n), 32'd0);
      do_cmd(C_COEF, 2'(n), 32'h0000_4000);
    end
    run(16'd2, 32'h0001_0000, 32'd0, 0, dat);
    check("jac_done_cycle", 32'(dat), 32'd27);
    check("jac_step_cnt", 32'(step_cnt), 32'd2);
    rd_check("jac_v0", 2'd0, 32'h0000_6000);
    rd_check("jac_v1", 2'd1, 32'h0000_1000);
    rd_check("jac_v2", 2'd2, 32'd0);
    rd_check("jac_v3", 2'd3, 32'd0);
    post_done("jac_after_done");

    // Zero steps
    run(16'd0, 32'h0001_0000, 32'd0, 0, dat);
    check("zero_done_cycle", 32'(dat), 32'd1);
    check("zero_step_cnt", 32'(step_cnt), 32'd0);
    rd_check("zero_v0", 2'd0, 32'h0000_6000);
    rd_check("zero_v1", 2'd1, 32'h0000_1000);
    post_done("zero_after_done");

    // Abort during the first step
    run(16'd100, 32'h0001_0000, 32'd0, 5, dat);
    check("abort_done_cycle", 32'(dat), 32'd14);
    check("abort_step_cnt", 32'(step_cnt), 32'd1);
    rd_check("abort_v0", 2'd0, 32'h0000_7400);
    rd_check("abort_v1", 2'd1, 32'h0000_2000);
    rd_check("abort_v2", 2'd2, 32'h0000_0400);
    rd_check("abort_v3", 2'd3, 32'd0);
    post_done("abort_after_done");

    // Positive overflow at both ends
    for (int n = 0; n < 4; n++) begin
      do_cmd(C_NODE, 2'(n), 32'h7000_0000);
      do_cmd(C_COEF, 2'(n), 32'h0002_0000);
    end
    run(16'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, dat);
    check("satp_done_cycle", 32'(dat), 32'd14);
    rd_check("satp_v0", 2'd0, EXP_POS);
    rd_check("satp_v1", 2'd1, 32'h7000_0000);
    rd_check("satp_v2", 2'd2, 32'h7000_0000);
    rd_check("satp_v3", 2'd3, EXP_POS);

    // Negative overflow at both ends
    @(negedge clk);
    for (int n = 0; n < 4; n++) do_cmd(C_NODE, 2'(n), 32'h9000_0000);
    run(16'd1, 32'h8000_0000, 32'h8000_0000, 0, dat);
    rd_check("satn_v0", 2'd0, EXP_NEG);
    rd_check("satn_v1", 2'd1, 32'h9000_0000);
    rd_check("satn_v3", 2'd3, EXP_NEG);

    // Handshake: a command held during a run lands after DONE
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      do_cmd(C_NODE, 2'(n), (n == 1) ? 32'd5 : 32'd0);
      do_cmd(C_COEF, 2'(n), 32'd0);
    end
    cmd = C_RUN; steps = 16'd1; bc_left = '0; bc_right = '0; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd = C_NODE; addr = 2'd1; addr2 = 3'd1; wdata = 32'h0000_ABCD;
    rd_addr = 2'd1;
    dat = -1;
    for (int c = 1; c <= 200; c++) begin
      #1;
      if (c == 6) begin
        check("hs_ready_low", 32'(cmd_ready), 32'd0);
        check("hs_no_write_mid", rd_data, 32'd5);
      end
      if (done) begin
        dat = c;
        break;
      end
      @(negedge clk);
    end
    check("hs_done_cycle", 32'(dat), 32'd14);
    check("hs_no_write_done", rd_data, 32'd5);
    @(negedge clk); #1;
    check("hs_ready_idle", 32'(cmd_ready), 32'd1);
    check("hs_pending", rd_data, 32'd5);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("hs_landed", rd_data, 32'h0000_ABCD);

    // Reset in the middle of a run
    @(negedge clk);
    cmd = C_RUN; steps = 16'd5; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("mrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_ctrl", 32'({cmd_ready, busy, done}), 32'b100);
    check("mrst_step_cnt", 32'(step_cnt), 32'd0);
    check("mrst_rd", rd_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (done) seen++;
    end
    check("mrst_no_done", 32'(seen), 32'd0);
    check("mrst_idle", 32'({cmd_ready, busy}), 32'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fea_node_seq.md
# fea_node_seq

Time-multiplexed explicit-Euler update engine for a 1-D FEA rod of `DEPTH` nodes. It stores node values and per-node coefficients (`k*dt/dx^2`, host-precomputed, allowing non-uniform grids), then runs N Jacobi time steps through one shared signed fixed-point datapath. It replaces per-node combinational update cells in the solver array and is driven by the same command-style host interface.

## Interface
- `WIDTH`, 32: signed fixed-point word width of values and coefficients.
- `FRAC`, 16: fractional bits, applying to both values and coefficients.
- `DEPTH`, 8: number of nodes, ≥2. `AW = $clog2(DEPTH)`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd` in 3: 0 WR_PROTECT, 1 SET_NODE, 2 SET_COEF, 3 RUN, 4–7 NOP.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE. A transfer occurs when `cmd_valid && cmd_ready`.
- `addr` in AW: node index for SET_NODE and SET_COEF.
- `wdata` in WIDTH: value, coefficient, or protect bit (`wdata[0]`).
- `steps` in 16: step count for RUN.
- `bc_left`, `bc_right` in WIDTH: Dirichlet boundary values, latched on RUN accept.
- `abort` in 1: ends a run at the next step boundary.
- `rd_addr` in AW; `rd_data` out WIDTH: combinational read of node value; returns 0 if `rd_addr ≥ DEPTH`.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `done` out 1: one-cycle pulse when a run ends.
- `step_cnt` out 16: number of steps completed in the current or last run.

## Operation
- **WR_PROTECT:** `prot <= wdata[0]`. While `prot=1`, SET_NODE and SET_COEF are accepted but have no effect.
- **SET_NODE / SET_COEF:** write `val[addr]` or `coef[addr]`. Writes with `addr ≥ DEPTH` are ignored.
- **RUN:** latch `steps`, `bc_left`, and `bc_right`; clear `step_cnt`; move to LAP with `i=0` and `lold=bc_left`.
- **FSM states:** IDLE → LAP → MUL → WB → (LAP for i+1 | STEP_END when i=DEPTH-1) → (LAP with i=0 | DONE) → IDLE.
  - LAP: `lap = lold + R - 2*val[i]`, computed at WIDTH+2 bits with no overflow. `R = val[i+1]`, or latched `bc_right` when i=DEPTH-1.
  - MUL: `d = (coef[i]*lap) >>> FRAC`, arithmetic shift (floor); full product width is 2*WIDTH+2.
  - WB: `lold <= val[i]` (the old value); `val[i] <= fit(val[i] + d)`.
  - STEP_END: `step_cnt++`. Go to DONE if `step_cnt+1 == steps` or `abort` was seen during this step; otherwise reload `lold=bc_left`, set `i=0`, and go to LAP.
  - DONE: `done=1` for one cycle, then IDLE.
- **Jacobi semantics:** every node update within a step uses only previous-step values. The in-place write is made safe by `lold`.
- **Zero steps:** `steps=0` goes from the accept cycle directly to DONE.
- **Abort:** `abort` is sticky until STEP_END, so a partial step always completes. Abort asserted in IDLE is ignored.
- **Reads during a run:** `rd_data` may mix old- and new-step values. Commands are not accepted while busy.

## Timing
- Each node takes 3 cycles (LAP, MUL, WB); each step takes 3*DEPTH+1 cycles.
- With RUN accepted at edge 0, `done` is high in cycle 1+S*(3*DEPTH+1) (cycle 1 when S=0). `cmd_ready` rises in the following cycle.
- `rd_data` is combinational from `val` and `rd_addr`. A write is visible on `rd_data` the cycle after its edge.
- Reset mid-run is immediate: FSM goes to IDLE, the run is lost, and no `done` pulse is produced.
- **Reset values:** `val[*]=0`, `coef[*]=0`, `prot=0`, `cmd_ready=1`, `busy=0`, `done=0`, `step_cnt=0`, `rd_data=0`.

## Configuration
- `FEA_NODE_SAT_EN` defined: `fit()` clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- `FEA_NODE_SAT_EN` undefined: `fit()` truncates to WIDTH bits, giving two's-complement wrap.

## Test plan
Unless stated otherwise, tests use WIDTH=32, FRAC=16, DEPTH=4.

- **Jacobi check:**
  - Setup: `coef[*]=0x4000`, `val[*]=0`, `bc_left=0x10000`, `bc_right=0`, RUN steps=2.
  - Expected: `val` = {0x6000, 0x1000, 0, 0}, `step_cnt=2`. `val[1]=0x1800` indicates a Gauss–Seidel bug.
  - Expected: `done` pulse in cycle 27.
- **Saturation:**
  - Setup: `val[*]=0x7000_0000`, `coef[*]=0x20000`, `bc_left=bc_right=0x7FFF_FFFF`, steps=1.
  - With `FEA_NODE_SAT_EN`: `val[0]=val[3]=0x7FFF_FFFF`.
  - Without `FEA_NODE_SAT_EN`: `val[0]=val[3]=0x8FFF_FFFE`.
  - Either build: `val[1]=val[2]=0x7000_0000`.
- **Write protect:** WR_PROTECT with `wdata=1`, then SET_NODE to addr 2 with 0x1234 → `rd_data(2)` is unchanged. WR_PROTECT with `wdata=0`, then SET_NODE again → `rd_data(2)=0x1234`.
- **Zero steps and abort:**
  - RUN steps=0 → `done` in cycle 1 and `val` unchanged.
  - RUN steps=100 with `abort` pulsed at cycle 5 → `done` at cycle 14, `step_cnt=1`.
- **Handshake:** `cmd_valid` held high with SET_NODE during a run → `cmd_ready=0` and no write occurs. The write lands on the cycle after DONE.
- **Reset mid-run:** `rst_n` low at cycle 7 of a run → all outputs return to their reset values immediately and no `done` pulse follows.
